alu_exec_stage: RTL and testbench

Execute-issue stage that sits directly upstream of the combinational ALU and also captures its outputs.
- Accepts operations (opcode plus two 32-bit operands) over a valid/ready handshake.
- Holds the ALU input ports stable for the required number of cycles.
- Registers result and flags into an output slice with its own valid/ready handshake toward writeback.
- MUL is treated as a multicycle path, held for MUL_LAT cycles.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_out_slice.sv | 54 +++++
 rtl/alu_exec_stage.sv | 112 +++++++++++
 tb/tb_alu_exec_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, FSM encoding and payload structs.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPC_W  = 3;

    localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OPC_W-1:0] OP_MUL  = 3'b010;
    localparam logic [OPC_W-1:0] OP_AND  = 3'b011;
    localparam logic [OPC_W-1:0] OP_OR   = 3'b100;
    localparam logic [OPC_W-1:0] OP_NAND = 3'b101;
    localparam logic [OPC_W-1:0] OP_NOR  = 3'b110;
    localparam logic [OPC_W-1:0] OP_XOR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MUL_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } alu_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              flag_c;
        logic              flag_z;
    } alu_rsp_t;

    // Only arithmetic ops produce a meaningful carry; the ALU keeps a stale one otherwise.
    function automatic logic carry_valid(input logic [OPC_W-1:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_out_slice.sv
// Output capture slice: registers ALU result/flags, masks carry, holds under backpressure.
// Optional sticky carry indicator when ALU_EXEC_STICKY_EN is defined.
module alu_out_slice
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
`ifdef ALU_EXEC_STICKY_EN
    input  logic              sticky_clr,
    output logic              sticky_c,
`endif
    input  logic              capture,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_flag_c,
    input  logic              alu_flag_z,
    input  logic              out_ready,
    output logic              out_valid,
    output alu_rsp_t          rsp
);

    logic masked_c;

    assign masked_c = carry_valid(opcode) & alu_flag_c;

    // Payload loads only on capture, so it is naturally stable while waiting for out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rsp       <= '0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            rsp.result <= alu_result;
            rsp.flag_c <= masked_c;
            rsp.flag_z <= alu_flag_z;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_EXEC_STICKY_EN
    // A carry capture outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_c <= 1'b0;
        end else if (capture && masked_c) begin
            sticky_c <= 1'b1;
        end else if (sticky_clr) begin
            sticky_c <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-issue stage: accepts ops, holds ALU inputs (MUL as multicycle), captures results.
// Optional feature macro: ALU_EXEC_STICKY_EN (adds sticky_c / sticky_clr).
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ALU_EXEC_STICKY_EN
    input  logic              sticky_clr,
    output logic              sticky_c,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_flagC,
    input  logic              alu_flagZ,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_flagC,
    output logic              out_flagZ,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;

    state_t            state;
    logic [CNT_W-1:0]  counter;
    alu_req_t          req;
    alu_rsp_t          rsp;
    logic              accept;
    logic              capture;

    // DONE lets a new op in on the same edge the result is taken.
    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign capture  = (state == ST_EXEC) || ((state == ST_MUL_WAIT) && (counter == '0));
    assign busy     = (state != ST_IDLE);

    assign alu_opcode   = req.opcode;
    assign alu_operand1 = req.op1;
    assign alu_operand2 = req.op2;

    assign out_result = rsp.result;
    assign out_flagC  = rsp.flag_c;
    assign out_flagZ  = rsp.flag_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            counter <= '0;
            req     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        req.opcode <= in_opcode;
                        req.op1    <= in_op1;
                        req.op2    <= in_op2;
                        if ((in_opcode == OP_MUL) && (MUL_LAT > 1)) begin
                            state   <= ST_MUL_WAIT;
                            counter <= CNT_W'(MUL_LAT - 1);
                        end else begin
                            state <= ST_EXEC;
                        end
                    end else if ((state == ST_DONE) && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    state <= ST_DONE;
                end
                ST_MUL_WAIT: begin
                    if (counter == '0) begin
                        state <= ST_DONE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    alu_out_slice u_out_slice (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef ALU_EXEC_STICKY_EN
        .sticky_clr (sticky_clr),
        .sticky_c   (sticky_c),
`endif
        .capture    (capture),
        .opcode     (req.opcode),
        .alu_result (alu_result),
        .alu_flag_c (alu_flagC),
        .alu_flag_z (alu_flagZ),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .rsp        (rsp)
    );

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage with a behavioural ALU and reference model.
module tb_alu_exec_stage;
    import alu_pkg::*;

    localparam int unsigned MUL_LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_opcode;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_operand1;
    logic [31:0] alu_operand2;
    logic [31:0] alu_result;
    logic        alu_flagC;
    logic        alu_flagZ;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_flagC;
    logic        out_flagZ;
    logic        busy;
    logic        stale_c;
    logic [32:0] alu_wide;
`ifdef ALU_EXEC_STICKY_EN
    logic        sticky_clr;
    logic        sticky_c;
`endif

    int n_chk;
    int n_fail;

    alu_exec_stage #(.MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef ALU_EXEC_STICKY_EN
        .sticky_clr   (sticky_clr),
        .sticky_c     (sticky_c),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_op1       (in_op1),
        .in_op2       (in_op2),
        .alu_opcode   (alu_opcode),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_result   (alu_result),
        .alu_flagC    (alu_flagC),
        .alu_flagZ    (alu_flagZ),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flagC    (out_flagC),
        .out_flagZ    (out_flagZ),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU: carry is real for ADD/SUB, stale (stale_c) otherwise.
    always_comb begin
        alu_wide   = '0;
        alu_result = '0;
        alu_flagC  = stale_c;
        case (alu_opcode)
            3'd0: begin
                alu_wide   = {1'b0, alu_operand1} + {1'b0, alu_operand2};
                alu_result = alu_wide[31:0];
                alu_flagC  = alu_wide[32];
            end
            3'd1: begin
                alu_wide   = {1'b0, alu_operand1} + {1'b0, ~alu_operand2} + 33'd1;
                alu_result = alu_wide[31:0];
                alu_flagC  = alu_wide[32];
            end
            3'd2: alu_result = alu_operand1 * alu_operand2;
            3'd3: alu_result = alu_operand1 & alu_operand2;
            3'd4: alu_result = alu_operand1 | alu_operand2;
            3'd5: alu_result = ~(alu_operand1 & alu_operand2);
            3'd6: alu_result = ~(alu_operand1 | alu_operand2);
            default: alu_result = alu_operand1 ^ alu_operand2;
        endcase
        alu_flagZ = (alu_result == 32'd0);
    end

    // Reference: architectural result and masked carry straight from the opcode definition.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic c);
        logic [63:0] wide;
        c = 1'b0;
        r = '0;
        case (op)
            3'd0: begin wide = 64'(a) + 64'(b); r = wide[31:0]; c = (wide >= 64'h1_0000_0000); end
            3'd1: begin r = a - b; c = (a >= b); end
            3'd2: begin wide = 64'(a) * 64'(b); r = wide[31:0]; end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a ^ b;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait for out_valid; lat = edges after the accept edge, -1 on timeout.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        in_opcode = op; in_op1 = a; in_op2 = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin step(); lat++; end
        if (!out_valid) lat = -1;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_chk++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL reset_out_result: got %h want 0", out_result); end
        n_chk++; if ({out_flagC, out_flagZ} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {out_flagC, out_flagZ}); end
        n_chk++; if ({alu_opcode, alu_operand1, alu_operand2} !== 67'd0) begin n_fail++; $display("FAIL reset_alu_ports: got %h %h %h want 0", alu_opcode, alu_operand1, alu_operand2); end
        n_chk++; if ({busy, in_ready} !== 2'b01) begin n_fail++; $display("FAIL reset_busy_ready: got %b want 01", {busy, in_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        int lat;
        run_op(OP_ADD, 32'd5, 32'd7, lat);
        n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
        n_chk++; if (out_result !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h want 0000000c", out_result); end
        n_chk++; if ({out_flagC, out_flagZ} !== 2'b00) begin n_fail++; $display("FAIL add_flags: got %b want 00", {out_flagC, out_flagZ}); end
        n_chk++; if ({in_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL add_done_ready_busy: got %b want 01", {in_ready, busy}); end
        repeat (2) begin
            step();
            n_chk++; if ({alu_opcode, alu_operand1, alu_operand2} !== {OP_ADD, 32'd5, 32'd7}) begin n_fail++; $display("FAIL add_alu_stable: got %h %h %h want 0 5 7", alu_opcode, alu_operand1, alu_operand2); end
        end
        pop();
        n_chk++; if ({out_valid, in_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL add_after_pop: got %b want 010", {out_valid, in_ready, busy}); end
    endtask

    task automatic test_sub_and();
        int lat;
        run_op(OP_SUB, 32'd3, 32'd3, lat);
        n_chk++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL sub_result: got %h want 0", out_result); end
        n_chk++; if ({out_flagC, out_flagZ} !== 2'b11) begin n_fail++; $display("FAIL sub_flags: got %b want 11", {out_flagC, out_flagZ}); end
        pop();
        stale_c = 1'b1;
        run_op(OP_AND, 32'hF0, 32'h0F, lat);
        n_chk++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL and_result: got %h want 0", out_result); end
        n_chk++; if ({out_flagC, out_flagZ} !== 2'b01) begin n_fail++; $display("FAIL and_flags_masked: got %b want 01", {out_flagC, out_flagZ}); end
        pop();
    endtask

    task automatic test_mul();
        in_opcode = OP_MUL; in_op1 = 32'h10; in_op2 = 32'h20; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < int'(MUL_LAT); i++) begin
            n_chk++; if ({out_valid, in_ready, busy} !== 3'b001) begin n_fail++; $display("FAIL mul_wait_cycle%0d: got %b want 001", i, {out_valid, in_ready, busy}); end
            step();
        end
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_latency: got out_valid=%b want 1", out_valid); end
        n_chk++; if (out_result !== 32'h200) begin n_fail++; $display("FAIL mul_result: got %h want 00000200", out_result); end
        pop();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(OP_XOR, 32'hFFFF0000, 32'h0000FFFF, lat);
        n_chk++; if (out_result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL xor_result: got %h want ffffffff", out_result); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++; if ({out_valid, in_ready, out_result} !== {2'b10, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL bp_hold%0d: got %b %b %h want 1 0 ffffffff", i, out_valid, in_ready, out_result); end
        end
        in_opcode = OP_OR; in_op1 = 32'd1; in_op2 = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_follows_out_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        n_chk++; if ({out_valid, alu_opcode} !== {1'b0, OP_OR}) begin n_fail++; $display("FAIL bp_same_edge_accept: got %b %h want 0 4", out_valid, alu_opcode); end
        step();
        n_chk++; if ({out_valid, out_result} !== {1'b1, 32'd3}) begin n_fail++; $display("FAIL bp_next_result: got %b %h want 1 00000003", out_valid, out_result); end
        pop();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        in_opcode = OP_MUL; in_op1 = 32'd9; in_op2 = 32'd9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({out_valid, busy, in_ready, out_result} !== {3'b001, 32'd0}) begin n_fail++; $display("FAIL rstmid_outputs: got %b %b %b %h want 0 0 1 0", out_valid, busy, in_ready, out_result); end
        n_chk++; if ({alu_opcode, alu_operand1, alu_operand2} !== 67'd0) begin n_fail++; $display("FAIL rstmid_alu_ports: got %h %h %h want 0", alu_opcode, alu_operand1, alu_operand2); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_output%0d: got %b want 0", i, out_valid); end
        end
        run_op(OP_ADD, 32'd1, 32'd1, lat);
        n_chk++; if ({lat == 1, out_result} !== {1'b1, 32'd2}) begin n_fail++; $display("FAIL rstmid_add: got lat=%0d %h want lat=1 00000002", lat, out_result); end
        pop();
    endtask

    task automatic test_random();
        int lat;
        int hold;
        int exp_lat;
        logic [2:0]  op;
        logic [31:0] a, b, er;
        logic        ec;
        for (int t = 0; t < 60; t++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            stale_c = 1'($urandom_range(0, 1));
            ref_op(op, a, b, er, ec);
            exp_lat = (op == OP_MUL) ? int'(MUL_LAT) : 1;
            run_op(op, a, b, lat);
            n_chk++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency op=%0d: got %0d want %0d", t, op, lat, exp_lat); end
            n_chk++; if (out_result !== er) begin n_fail++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", t, op, a, b, out_result, er); end
            n_chk++; if ({out_flagC, out_flagZ} !== {ec, er == 32'd0}) begin n_fail++; $display("FAIL rnd%0d_flags op=%0d: got %b want %b", t, op, {out_flagC, out_flagZ}, {ec, er == 32'd0}); end
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
                step();
                n_chk++; if ({out_valid, out_result} !== {1'b1, er}) begin n_fail++; $display("FAIL rnd%0d_hold%0d: got %b %h want 1 %h", t, k, out_valid, out_result, er); end
            end
            pop();
        end
    endtask

`ifdef ALU_EXEC_STICKY_EN
    task automatic test_sticky();
        int lat;
        sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
        n_chk++; if (sticky_c !== 1'b0) begin n_fail++; $display("FAIL sticky_initial_clear: got %b want 0", sticky_c); end
        run_op(OP_ADD, 32'hFFFFFFFF, 32'd1, lat);
        n_chk++; if ({out_flagC, sticky_c} !== 2'b11) begin n_fail++; $display("FAIL sticky_set: got %b want 11", {out_flagC, sticky_c}); end
        pop();
        stale_c = 1'b1;
        run_op(OP_AND, 32'd1, 32'd1, lat);
        n_chk++; if (sticky_c !== 1'b1) begin n_fail++; $display("FAIL sticky_retained: got %b want 1", sticky_c); end
        pop();
        sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
        n_chk++; if (sticky_c !== 1'b0) begin n_fail++; $display("FAIL sticky_clear: got %b want 0", sticky_c); end
        in_opcode = OP_ADD; in_op1 = 32'hFFFFFFFF; in_op2 = 32'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0; sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        n_chk++; if ({out_valid, sticky_c} !== 2'b11) begin n_fail++; $display("FAIL sticky_set_wins: got %b want 11", {out_valid, sticky_c}); end
        pop();
    endtask
`endif

    initial begin
        n_chk = 0; n_fail = 0;
        in_valid = 1'b0; in_opcode = '0; in_op1 = '0; in_op2 = '0;
        out_ready = 1'b0; stale_c = 1'b0;
`ifdef ALU_EXEC_STICKY_EN
        sticky_clr = 1'b0;
`endif
        test_reset();
        test_add();
        test_sub_and();
        test_mul();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
`ifdef ALU_EXEC_STICKY_EN
        test_sticky();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
